fft_output_unloader: RTL and testbench

- Receiving end of the pipelined FFT stage pair interface. Sits after the last butterfly stage.
- Captures 512 butterfly pairs per 1024-point frame into a ping-pong RAM.
- Streams the frame out one complex sample per transfer in natural bin order, undoing the internal bit-reversed order.
- Uses a valid/ready handshake toward the downstream consumer and flags lost frames.

---
 rtl/fft_output_unloader.sv | 196 +++++++++++++++++++
 tb/tb_fft_output_unloader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_unloader.sv
// Ping-pong frame buffer after the last FFT butterfly stage; streams each 1024-point
// frame out in natural bin order. Define FFT_UNLOAD_FFTSHIFT_EN for fftshifted output.
module fft_output_unloader #(
   parameter int DATA_W = 32,
   parameter int LOG2N  = 10
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid_in,
   input  logic [DATA_W-1:0] i_data_a_real,
   input  logic [DATA_W-1:0] i_data_a_imag,
   input  logic [DATA_W-1:0] i_data_b_real,
   input  logic [DATA_W-1:0] i_data_b_imag,
   input  logic              i_ready,
   output logic              o_valid_out,
   output logic [DATA_W-1:0] o_data_real,
   output logic [DATA_W-1:0] o_data_imag,
   output logic [LOG2N-1:0]  o_index,
   output logic              o_last,
   output logic              o_overflow
);

   localparam int N = 1 << LOG2N;

`ifdef FFT_UNLOAD_FFTSHIFT_EN
   localparam logic [LOG2N-1:0] IDX_XOR = {1'b1, {(LOG2N-1){1'b0}}};
`else
   localparam logic [LOG2N-1:0] IDX_XOR = '0;
`endif

   typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   // Element A holds even internal indices, element B odd; both banks share each array.
   logic [2*DATA_W-1:0] mem_a [N];
   logic [2*DATA_W-1:0] mem_b [N];

   logic [LOG2N-2:0]  wr_cnt;
   logic              wr_bank;
   logic              dropping;
   logic [1:0]        full;

   rd_state_t         state;
   logic [LOG2N-1:0]  rd_cnt;
   logic              rd_bank;

   logic [2*DATA_W-1:0] ram_qa, ram_qb;
   logic              ram_vld, ram_sel, ram_last;
   logic [LOG2N-1:0]  ram_idx;

   logic              skid_vld, skid_last;
   logic [DATA_W-1:0] skid_real, skid_imag;
   logic [LOG2N-1:0]  skid_idx;

   logic              frame_start, wr_drop, wr_en, wr_done;
   logic              pop, issue, last_done;
   logic [1:0]        occ;
   logic [LOG2N-1:0]  rd_idx, rd_addr;
   logic [2*DATA_W-1:0] ram_sample;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned
   // (which would infer a latch); combinational logic uses blocking '='.
   always_comb begin
      frame_start = i_valid_in && (wr_cnt == '0);
      wr_drop     = frame_start ? full[wr_bank] : dropping;
      wr_en       = i_valid_in && !wr_drop;
      wr_done     = wr_en && (wr_cnt == '1);

      rd_idx      = rd_cnt ^ IDX_XOR;
      rd_addr     = bitrev(rd_idx);
      pop         = o_valid_out && i_ready;
      // Slots committed after this edge: FIFO entries plus the read in flight, less the pop.
      occ         = 2'(o_valid_out) + 2'(skid_vld) + 2'(ram_vld) - 2'(pop);
      issue       = (state == READ) && (occ < 2'd2);
      last_done   = (state == DRAIN) && pop && o_last;
      ram_sample  = ram_sel ? ram_qb : ram_qa;
   end

   // NOTE: the RAM and its read data register have no reset; a reset only discards
   // the frame bookkeeping, so stale contents are never observed.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_a[{wr_bank, wr_cnt}] <= {i_data_a_real, i_data_a_imag};
         mem_b[{wr_bank, wr_cnt}] <= {i_data_b_real, i_data_b_imag};
      end
      if (issue) begin
         ram_qa <= mem_a[{rd_bank, rd_addr[LOG2N-1:1]}];
         ram_qb <= mem_b[{rd_bank, rd_addr[LOG2N-1:1]}];
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         wr_cnt     <= '0;
         wr_bank    <= 1'b0;
         dropping   <= 1'b0;
         o_overflow <= 1'b0;
      end else if (i_valid_in) begin
         wr_cnt   <= wr_cnt + 1'b1;
         dropping <= wr_drop;
         if (frame_start && full[wr_bank]) o_overflow <= 1'b1;
         if (wr_done) wr_bank <= ~wr_bank;
      end
   end

   // Write completion and read drain never target the same bank in one cycle.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         full <= '0;
      end else begin
         if (wr_done)   full[wr_bank] <= 1'b1;
         if (last_done) full[rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state       <= IDLE;
         rd_cnt      <= '0;
         rd_bank     <= 1'b0;
         ram_vld     <= 1'b0;
         ram_sel     <= 1'b0;
         ram_idx     <= '0;
         ram_last    <= 1'b0;
         skid_vld    <= 1'b0;
         skid_real   <= '0;
         skid_imag   <= '0;
         skid_idx    <= '0;
         skid_last   <= 1'b0;
         o_valid_out <= 1'b0;
         o_data_real <= '0;
         o_data_imag <= '0;
         o_index     <= '0;
         o_last      <= 1'b0;
      end else begin
         ram_vld <= issue;
         if (issue) begin
            ram_sel  <= rd_addr[0];
            ram_idx  <= rd_idx;
            ram_last <= (rd_cnt == '1);
         end

         case (state)
            IDLE: if (full[rd_bank]) begin
               state  <= READ;
               rd_cnt <= '0;
            end
            READ: if (issue) begin
               rd_cnt <= rd_cnt + 1'b1;
               if (rd_cnt == '1) state <= DRAIN;
            end
            DRAIN: if (last_done) begin
               rd_bank <= ~rd_bank;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Two-entry FIFO: the output register is the head, the skid register the tail.
         if (!o_valid_out || pop) begin
            if (skid_vld) begin
               o_valid_out <= 1'b1;
               o_data_real <= skid_real;
               o_data_imag <= skid_imag;
               o_index     <= skid_idx;
               o_last      <= skid_last;
               skid_vld    <= ram_vld;
               if (ram_vld) begin
                  {skid_real, skid_imag} <= ram_sample;
                  skid_idx  <= ram_idx;
                  skid_last <= ram_last;
               end
            end else begin
               o_valid_out <= ram_vld;
               if (ram_vld) begin
                  {o_data_real, o_data_imag} <= ram_sample;
                  o_index <= ram_idx;
                  o_last  <= ram_last;
               end
            end
         end else if (ram_vld) begin
            skid_vld <= 1'b1;
            {skid_real, skid_imag} <= ram_sample;
            skid_idx  <= ram_idx;
            skid_last <= ram_last;
         end
      end
   end

endmodule

// File: tb/tb_fft_output_unloader.sv
// Scoreboard bench for fft_output_unloader: table of frame scenarios plus hand-written
// reset, latency and reset-mid-read sequences.
module tb_fft_output_unloader;

   localparam int DATA_W = 32;
   localparam int LOG2N  = 10;
   localparam int N      = 1024;
`ifdef FFT_UNLOAD_FFTSHIFT_EN
   localparam logic [9:0] IDX_XOR = 10'd512;
`else
   localparam logic [9:0] IDX_XOR = 10'd0;
`endif

   logic              i_clk = 1'b0;
   logic              i_reset = 1'b0;
   logic              i_valid_in = 1'b0;
   logic [DATA_W-1:0] i_data_a_real = '0, i_data_a_imag = '0;
   logic [DATA_W-1:0] i_data_b_real = '0, i_data_b_imag = '0;
   logic              i_ready = 1'b0;
   logic              o_valid_out;
   logic [DATA_W-1:0] o_data_real, o_data_imag;
   logic [LOG2N-1:0]  o_index;
   logic              o_last;
   logic              o_overflow;

   fft_output_unloader #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid_in   (i_valid_in),
      .i_data_a_real(i_data_a_real),
      .i_data_a_imag(i_data_a_imag),
      .i_data_b_real(i_data_b_real),
      .i_data_b_imag(i_data_b_imag),
      .i_ready      (i_ready),
      .o_valid_out  (o_valid_out),
      .o_data_real  (o_data_real),
      .o_data_imag  (o_data_imag),
      .o_index      (o_index),
      .o_last       (o_last),
      .o_overflow   (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] re;
      logic [31:0] im;
      logic [9:0]  idx;
      logic        last;
   } sample_t;

   typedef enum {RDY_HIGH, RDY_LOW, RDY_TOGGLE, RDY_RAND} rdy_mode_t;

   typedef struct {
      string      name;
      int         nframes;
      int         gap;
      rdy_mode_t  in_mode;
      rdy_mode_t  out_mode;
      logic [3:0] keep;
      int         ovf_frame;
      bit         exp_ovf;
   } scen_t;

   sample_t   sb[$];
   rdy_mode_t rdy_mode = RDY_HIGH;
   int        n_pass  = 0;
   int        n_total = 0;
   int        n_xfer  = 0;
   bit        prev_stall = 1'b0;
   sample_t   held;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [9:0] bitrev10(input logic [9:0] v);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[i] = v[9-i];
      return r;
   endfunction

   // Natural bin idx is stored at internal index bitrev(idx), whose real part is base+bitrev(idx).
   task automatic push_frame(input logic [31:0] base);
      sample_t s;
      for (int n = 0; n < N; n++) begin
         s.idx  = 10'(n) ^ IDX_XOR;
         s.re   = base + 32'(bitrev10(s.idx));
         s.im   = ~s.re;
         s.last = (n == N - 1);
         sb.push_back(s);
      end
   endtask

   always @(posedge i_clk) begin
      #1;
      case (rdy_mode)
         RDY_HIGH:   i_ready = 1'b1;
         RDY_LOW:    i_ready = 1'b0;
         RDY_TOGGLE: i_ready = ~i_ready;
         RDY_RAND:   i_ready = 1'($urandom_range(0, 1));
         default:    i_ready = 1'b1;
      endcase
   end

   always @(negedge i_clk) begin
      sample_t e;
      if (!i_reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", 64'(o_valid_out), 64'd1);
            check("stall_data_held", {o_data_real, o_data_imag}, {held.re, held.im});
            check("stall_index_held", {o_index, o_last}, 64'({held.idx, held.last}));
         end
         if (o_valid_out && i_ready) begin
            check("transfer_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("out_real",  64'(o_data_real), 64'(e.re));
               check("out_imag",  64'(o_data_imag), 64'(e.im));
               check("out_index", 64'(o_index),     64'(e.idx));
               check("out_last",  64'(o_last),      64'(e.last));
            end
            n_xfer++;
         end
         prev_stall = o_valid_out && !i_ready;
         held.re   = o_data_real;
         held.im   = o_data_imag;
         held.idx  = o_index;
         held.last = o_last;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic rand_inputs();
      i_valid_in    = 1'($urandom_range(0, 1));
      i_data_a_real = $urandom();
      i_data_a_imag = $urandom();
      i_data_b_real = $urandom();
      i_data_b_imag = $urandom();
   endtask

   task automatic do_reset(input int cycles);
      i_reset = 1'b0;
      repeat (cycles) begin
         rand_inputs();
         tick();
      end
      i_valid_in = 1'b0;
      sb.delete();
      i_reset = 1'b1;
      n_xfer  = 0;
   endtask

   task automatic drive_frame(input int tag, input int gap, input bit keep, input bit exp_ovf);
      logic [31:0] base;
      logic [31:0] ra, rb;
      base = 32'(tag) << 16;
      for (int k = 0; k < N / 2; k++) begin
         ra = base + 32'(2 * k);
         rb = ra + 32'd1;
         i_valid_in    = 1'b1;
         i_data_a_real = ra;
         i_data_a_imag = ~ra;
         i_data_b_real = rb;
         i_data_b_imag = ~rb;
         if (k == N / 2 - 1 && keep) push_frame(base);
         tick();
         if (k == 0) check("overflow_at_frame_start", 64'(o_overflow), 64'(exp_ovf));
         i_valid_in = 1'b0;
         repeat (gap) tick();
      end
   endtask

   task automatic wait_empty(input string name, input int budget);
      int c = 0;
      while (sb.size() != 0 && c < budget) begin
         tick();
         c++;
      end
      check({name, "_drained"}, 64'(sb.size()), 64'd0);
      repeat (20) tick();
      check({name, "_idle_after"}, 64'(o_valid_out), 64'd0);
   endtask

   initial begin
      scen_t scen[4];
      int    lat;
      int    c;

      scen[0] = '{"backpressure",  1, 0, RDY_TOGGLE, RDY_TOGGLE, 4'b0001, 99, 1'b0};
      scen[1] = '{"back_to_back",  2, 1, RDY_HIGH,   RDY_HIGH,   4'b0011, 99, 1'b0};
      scen[2] = '{"overflow",      3, 0, RDY_LOW,    RDY_HIGH,   4'b0011,  2, 1'b1};
      scen[3] = '{"random_ready",  2, 1, RDY_RAND,   RDY_RAND,   4'b0011, 99, 1'b0};

      // Reset with random inputs: all outputs must be zero.
      rdy_mode = RDY_RAND;
      for (int i = 0; i < 4; i++) begin
         rand_inputs();
         tick();
      end
      check("reset_valid",    64'(o_valid_out), 64'd0);
      check("reset_real",     64'(o_data_real), 64'd0);
      check("reset_imag",     64'(o_data_imag), 64'd0);
      check("reset_index",    64'(o_index),     64'd0);
      check("reset_last",     64'(o_last),      64'd0);
      check("reset_overflow", 64'(o_overflow),  64'd0);
      i_valid_in = 1'b0;
      i_reset    = 1'b1;
      rdy_mode   = RDY_HIGH;
      repeat (30) tick();
      check("no_valid_before_frame", 64'(o_valid_out), 64'd0);

      // Ordering and first-valid latency with ready held high.
      drive_frame(1, 0, 1'b1, 1'b0);
      lat = 0;
      while (!o_valid_out && lat < 10) begin
         tick();
         lat++;
      end
      check("first_valid_latency", 64'(lat), 64'd3);
      wait_empty("ordering", 5000);
      check("ordering_xfers", 64'(n_xfer), 64'd1024);

      for (int s = 0; s < 4; s++) begin
         do_reset(3);
         rdy_mode = scen[s].in_mode;
         for (int f = 0; f < scen[s].nframes; f++)
            drive_frame(16 * s + f + 2, scen[s].gap, scen[s].keep[f], f >= scen[s].ovf_frame);
         rdy_mode = scen[s].out_mode;
         wait_empty(scen[s].name, 20000);
         check({scen[s].name, "_overflow_end"}, 64'(o_overflow), 64'(scen[s].exp_ovf));
      end

      // Reset after 100 output samples, then a fresh frame must come out from n=0.
      do_reset(3);
      rdy_mode = RDY_HIGH;
      drive_frame(100, 0, 1'b1, 1'b0);
      c = 0;
      while (n_xfer < 100 && c < 2000) begin
         tick();
         c++;
      end
      check("xfers_before_midreset", 64'(n_xfer), 64'd100);
      i_reset = 1'b0;
      tick();
      sb.delete();
      check("midreset_valid", 64'(o_valid_out), 64'd0);
      check("midreset_index", 64'(o_index),     64'd0);
      check("midreset_real",  64'(o_data_real), 64'd0);
      tick();
      i_reset = 1'b1;
      repeat (10) tick();
      check("midreset_no_valid", 64'(o_valid_out), 64'd0);
      n_xfer = 0;
      drive_frame(101, 0, 1'b1, 1'b0);
      wait_empty("after_midreset", 5000);
      check("after_midreset_xfers", 64'(n_xfer), 64'd1024);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
